// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding,
// requester limits and the inter-load gap counter width.
package uart_tx_arbiter_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;
  localparam int unsigned GAP_CNT_W   = 8;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_RDY,
    GAP
  } state_e;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin winner selection: scans requests starting one past the last
// granted index and returns a one-hot winner plus a valid flag.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((32'(last) + off) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART TX
// engine. Optional packet lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      tx_rdy,
  output logic                      tx_load,
  output logic [BYTE_W-1:0]         tx_load_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ out of range");
  end

  state_e               state, state_d;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     win_idx;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_d;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   winner;
  logic                 win_valid;
  logic                 take;
  logic [BYTE_W-1:0]    win_byte;

`ifdef UART_TX_ARB_LOCK_EN
  // A locked last winner keeps the channel until its lock bit drops.
  always_comb begin
    eligible = req;
    if (req_lock[last_grant]) begin
      eligible = req & (NUM_REQ'(1) << last_grant);
    end
  end
`else
  assign eligible = req;
`endif

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req    (eligible),
    .last   (last_grant),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx  = '0;
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = IDX_W'(i);
        win_byte = req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Next state; grant is a same-cycle pulse while arbitrating in IDLE.
  always_comb begin
    state_d   = state;
    gap_cnt_d = gap_cnt;
    take      = 1'b0;
    grant     = '0;
    case (state)
      IDLE: begin
        if (tx_rdy && win_valid && !reset) begin
          take    = 1'b1;
          grant   = winner;
          state_d = LOAD;
        end
      end
      LOAD: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_rdy) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (tx_rdy) begin
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_CNT_W'(GAP_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt - GAP_CNT_W'(1);
        if (gap_cnt <= GAP_CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      tx_load      <= 1'b0;
      tx_load_data <= '0;
      busy         <= 1'b0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
      tx_load <= (state_d == LOAD);
      busy    <= (state_d != IDLE);
      if (take) begin
        last_grant   <= win_idx;
        tx_load_data <= win_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a default instance and a GAP_CYCLES=5
// instance, each driven by a simple TX engine model (busy 20 cycles per load).
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        rdy_a, rdy_b;
  logic [3:0]  grant_a, grant_b;
  logic        load_a, load_b;
  logic [7:0]  data_a, data_b;
  logic        busy_a, busy_b;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  req_lock;
  logic [3:0]  lock_nx;
`endif

  logic        reset_nx, hold_nx;
  logic [3:0]  req_nx;
  logic [31:0] data_nx;
  int          cyc, cnt_a, cnt_b, onehot_bad;
  int          n_checks, n_errors;
  int          ga_cyc[$], ga_idx[$], gb_cyc[$], gb_idx[$], la_cyc[$];
  logic [7:0]  la_dat[$];
  int          n_load, base;
  logic [7:0]  lane_byte [4] = '{8'h10, 8'h11, 8'h12, 8'h13};

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .grant(grant_a), .tx_rdy(rdy_a), .tx_load(load_a),
    .tx_load_data(data_a), .busy(busy_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .grant(grant_b), .tx_rdy(rdy_b), .tx_load(load_b),
    .tx_load_data(data_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // One clock: drive inputs just after the edge, observe at the falling edge.
  task automatic cycle();
    @(posedge clock);
    #1;
    reset    = reset_nx;
    req      = req_nx;
    req_data = data_nx;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = lock_nx;
`endif
    if (cnt_a > 0) cnt_a--;
    if (cnt_b > 0) cnt_b--;
    rdy_a = !hold_nx && (cnt_a == 0);
    rdy_b = !hold_nx && (cnt_b == 0);
    @(negedge clock);
    cyc++;
    if ($countones(grant_a) > 1 || $countones(grant_b) > 1) onehot_bad++;
    if (grant_a != 4'd0) begin ga_cyc.push_back(cyc); ga_idx.push_back(oh_idx(grant_a)); end
    if (grant_b != 4'd0) begin gb_cyc.push_back(cyc); gb_idx.push_back(oh_idx(grant_b)); end
    if (load_a === 1'b1) begin cnt_a = 20; la_cyc.push_back(cyc); la_dat.push_back(data_a); end
    if (load_b === 1'b1) cnt_b = 20;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (ga_idx.size() < target && n < budget) begin cycle(); n++; end
    check($sformatf("wait_grant_%0d", target), 32'(ga_idx.size() >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy_a === 1'b0 && rdy_a === 1'b1 && busy_b === 1'b0 && rdy_b === 1'b1) && n < budget) begin
      cycle();
      n++;
    end
    check("wait_idle", 32'(n < budget), 1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; cnt_a = 0; cnt_b = 0; onehot_bad = 0;
    reset = 1'b1; req = '0; req_data = '0; rdy_a = 1'b1; rdy_b = 1'b1;
    reset_nx = 1'b1; hold_nx = 1'b0; req_nx = '0; data_nx = '0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = '0; lock_nx = '0;
`endif

    // Reset values
    cycle(); cycle();
    check("rst_grant", 32'(grant_a), 0);
    check("rst_load", 32'(load_a), 0);
    check("rst_data", 32'(data_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_busy_gap", 32'(busy_b), 0);
    reset_nx = 1'b0;

    // TX not ready: requests pend without grants or loads
    data_nx = 32'h13121110;
    req_nx  = 4'hF;
    hold_nx = 1'b1;
    repeat (6) cycle();
    check("hold_grants", 32'(ga_idx.size()), 0);
    check("hold_loads", 32'(la_cyc.size()), 0);
    hold_nx = 1'b0;
    cycle();
    check("release_grant", 32'(grant_a), 4'b0001);

    // Continuous requests rotate 0,1,2,3,0 with 22-cycle spacing
    wait_grants(5, 200);
    req_nx = 4'h0;
    if (ga_idx.size() >= 5 && la_cyc.size() >= 4 && gb_cyc.size() >= 2) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_idx_%0d", k), 32'(ga_idx[k]), 32'(k % 4));
      for (int k = 1; k < 5; k++) check($sformatf("rr_space_%0d", k), 32'(ga_cyc[k] - ga_cyc[k-1]), 22);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("load_lat_%0d", k), 32'(la_cyc[k] - ga_cyc[k]), 1);
        check($sformatf("load_dat_%0d", k), 32'(la_dat[k]), 32'(lane_byte[k]));
      end
      check("gap_space", 32'(gb_cyc[1] - gb_cyc[0]), 27);
      check("gap_extra", 32'(gb_cyc[1] - ga_cyc[1]), 5);
      check("gap_idx", 32'(gb_idx[1]), 1);
    end

    // Single request from requester 2
    wait_idle(100);
    data_nx = 32'h00A50000;
    req_nx  = 4'b0100;
    cycle();
    check("single_grant", 32'(grant_a), 4'b0100);
    req_nx = 4'h0;
    cycle();
    check("single_load", 32'(load_a), 1);
    check("single_data", 32'(data_a), 8'hA5);
    check("single_busy", 32'(busy_a), 1);
    repeat (4) cycle();
    check("data_hold", 32'(data_a), 8'hA5);
    check("load_one_shot", 32'(load_a), 0);

    // Reset while waiting for TX ready aborts the transaction
    wait_idle(100);
    req_nx = 4'b0010;
    cycle();
    check("pre_rst_grant", 32'(grant_a), 4'b0010);
    req_nx = 4'hF;
    repeat (6) cycle();
    n_load = la_cyc.size();
    base   = ga_idx.size();
    reset_nx = 1'b1;
    cycle();
    reset_nx = 1'b0;
    cycle();
    check("abort_busy", 32'(busy_a), 0);
    check("abort_load", 32'(load_a), 0);
    wait_grants(base + 1, 60);
    if (ga_idx.size() > base) check("rst_first_grant", 32'(ga_idx[base]), 0);
    check("rst_no_load", 32'(la_cyc.size() - n_load), 0);

`ifdef UART_TX_ARB_LOCK_EN
    // Locked requester 1 keeps the channel for three bytes, then 3 is served
    req_nx = 4'h0;
    wait_idle(100);
    base    = ga_idx.size();
    req_nx  = 4'b1011;
    lock_nx = 4'b0010;
    wait_grants(base + 3, 120);
    lock_nx = 4'b0000;
    wait_grants(base + 4, 60);
    if (ga_idx.size() >= base + 4) begin
      check("lock_0", 32'(ga_idx[base]), 1);
      check("lock_1", 32'(ga_idx[base+1]), 1);
      check("lock_2", 32'(ga_idx[base+2]), 1);
      check("lock_rel", 32'(ga_idx[base+3]), 3);
    end
`endif

    check("grant_onehot", 32'(onehot_bad), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
